// File: rtl/command_frame_pkg.sv
// Shared opcodes, command/state encodings and frame-layout helpers for command_frame_builder.
package command_frame_pkg;

  localparam logic [7:0] OPCODE_WRITE          = 8'hAA;
  localparam logic [7:0] OPCODE_READ           = 8'hBB;
  localparam logic [7:0] OPCODE_ALU_OPERAND    = 8'hCC;
  localparam logic [7:0] OPCODE_ALU_NO_OPERAND = 8'hDD;

  typedef enum logic [1:0] {
    CMD_WRITE          = 2'd0,
    CMD_READ           = 2'd1,
    CMD_ALU_OPERAND    = 2'd2,
    CMD_ALU_NO_OPERAND = 2'd3
  } command_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [2:0] frame_length(input command_type_t cmd_type);
    case (cmd_type)
      CMD_WRITE:       frame_length = 3'd3;
      CMD_READ:        frame_length = 3'd2;
      CMD_ALU_OPERAND: frame_length = 3'd4;
      default:         frame_length = 3'd2;
    endcase
  endfunction

  function automatic logic [7:0] opcode_of(input command_type_t cmd_type);
    case (cmd_type)
      CMD_WRITE:       opcode_of = OPCODE_WRITE;
      CMD_READ:        opcode_of = OPCODE_READ;
      CMD_ALU_OPERAND: opcode_of = OPCODE_ALU_OPERAND;
      default:         opcode_of = OPCODE_ALU_NO_OPERAND;
    endcase
  endfunction

  // Byte at position idx of a frame; positions past the frame length read as zero.
  function automatic logic [7:0] frame_byte(
    input command_type_t cmd_type,
    input logic [1:0]    idx,
    input logic [7:0]    address,
    input logic [7:0]    write_data,
    input logic [7:0]    operand_a,
    input logic [7:0]    operand_b,
    input logic [7:0]    alu_function
  );
    frame_byte = 8'h00;
    case (idx)
      2'd0: frame_byte = opcode_of(cmd_type);
      2'd1: begin
        case (cmd_type)
          CMD_WRITE, CMD_READ: frame_byte = address;
          CMD_ALU_OPERAND:     frame_byte = operand_a;
          default:             frame_byte = alu_function;
        endcase
      end
      2'd2: begin
        if (cmd_type == CMD_WRITE)            frame_byte = write_data;
        else if (cmd_type == CMD_ALU_OPERAND) frame_byte = operand_b;
      end
      default: begin
        if (cmd_type == CMD_ALU_OPERAND) frame_byte = alu_function;
      end
    endcase
  endfunction

endpackage

// File: rtl/command_frame_builder.sv
// Turns one latched host command into an opcode-led byte frame over a valid/ready stream.
// Optional inter-frame idle gap is built when CMD_FRAME_GAP_EN is defined.
module command_frame_builder
  import command_frame_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int REGISTER_FILE_DEPTH = 16
`ifdef CMD_FRAME_GAP_EN
  ,
  parameter int GAP_CYCLES          = 4
`endif
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   command_valid,
  output logic                                   command_ready,
  input  logic [1:0]                             command_type,
  input  logic [$clog2(REGISTER_FILE_DEPTH)-1:0] command_address,
  input  logic [DATA_WIDTH-1:0]                  command_write_data,
  input  logic [DATA_WIDTH-1:0]                  command_operand_A,
  input  logic [DATA_WIDTH-1:0]                  command_operand_B,
  input  logic [3:0]                             command_ALU_function,
  output logic                                   byte_valid,
  input  logic                                   byte_ready,
  output logic [DATA_WIDTH-1:0]                  byte_data,
  output logic                                   frame_busy,
  output logic [7:0]                             frame_count
);

  localparam int ADDR_WIDTH = $clog2(REGISTER_FILE_DEPTH);

  state_t                  state_reg;
  logic [1:0]              byte_index_reg;
  command_type_t           type_reg;
  logic [ADDR_WIDTH-1:0]   address_reg;
  logic [DATA_WIDTH-1:0]   write_data_reg;
  logic [DATA_WIDTH-1:0]   operand_a_reg;
  logic [DATA_WIDTH-1:0]   operand_b_reg;
  logic [3:0]              alu_function_reg;
  logic                    command_ready_reg;
  logic                    byte_valid_reg;
  logic [DATA_WIDTH-1:0]   byte_data_reg;
  logic                    frame_busy_reg;
  logic [7:0]              frame_count_reg;
`ifdef CMD_FRAME_GAP_EN
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
  logic [7:0]              gap_count_reg;
`endif

  logic                    accept;
  logic                    transfer;
  logic                    last_byte;
  logic [DATA_WIDTH-1:0]   frame_bytes [4];

  assign accept    = command_valid && command_ready_reg;
  assign transfer  = byte_valid_reg && byte_ready;
  assign last_byte = ({1'b0, byte_index_reg} + 3'd1) == frame_length(type_reg);

  // Every byte of the in-flight frame is precomputed from the latched command.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_frame_byte
      assign frame_bytes[gi] = frame_byte(type_reg, 2'(gi), 8'(address_reg),
                                          write_data_reg, operand_a_reg, operand_b_reg,
                                          {4'h0, alu_function_reg});
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      byte_index_reg    <= 2'd0;
      type_reg          <= CMD_WRITE;
      address_reg       <= '0;
      write_data_reg    <= '0;
      operand_a_reg     <= '0;
      operand_b_reg     <= '0;
      alu_function_reg  <= 4'h0;
      command_ready_reg <= 1'b0;
      byte_valid_reg    <= 1'b0;
      byte_data_reg     <= '0;
      frame_busy_reg    <= 1'b0;
      frame_count_reg   <= 8'h00;
`ifdef CMD_FRAME_GAP_EN
      gap_count_reg     <= 8'h00;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            type_reg          <= command_type_t'(command_type);
            address_reg       <= command_address;
            write_data_reg    <= command_write_data;
            operand_a_reg     <= command_operand_A;
            operand_b_reg     <= command_operand_B;
            alu_function_reg  <= command_ALU_function;
            state_reg         <= SEND;
            byte_index_reg    <= 2'd0;
            byte_valid_reg    <= 1'b1;
            byte_data_reg     <= opcode_of(command_type_t'(command_type));
            frame_busy_reg    <= 1'b1;
            command_ready_reg <= 1'b0;
          end else begin
            command_ready_reg <= 1'b1;
          end
        end

        SEND: begin
          if (transfer) begin
            if (last_byte) begin
              frame_count_reg <= frame_count_reg + 8'd1;
              byte_valid_reg  <= 1'b0;
              byte_data_reg   <= '0;
              byte_index_reg  <= 2'd0;
`ifdef CMD_FRAME_GAP_EN
              state_reg       <= GAP;
              gap_count_reg   <= GAP_LOAD;
`else
              state_reg         <= IDLE;
              command_ready_reg <= 1'b1;
              frame_busy_reg    <= 1'b0;
`endif
            end else begin
              byte_index_reg <= byte_index_reg + 2'd1;
              byte_data_reg  <= frame_bytes[byte_index_reg + 2'd1];
            end
          end
        end

`ifdef CMD_FRAME_GAP_EN
        GAP: begin
          // The cycle that sees zero is the last gap cycle.
          if (gap_count_reg == 8'h00) begin
            state_reg         <= IDLE;
            command_ready_reg <= 1'b1;
            frame_busy_reg    <= 1'b0;
          end else begin
            gap_count_reg <= gap_count_reg - 8'd1;
          end
        end
`endif

        default: begin
          state_reg         <= IDLE;
          byte_valid_reg    <= 1'b0;
          frame_busy_reg    <= 1'b0;
          command_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign command_ready = command_ready_reg;
  assign byte_valid    = byte_valid_reg;
  assign byte_data     = byte_data_reg;
  assign frame_busy    = frame_busy_reg;
  assign frame_count   = frame_count_reg;

endmodule
